rgb_pwm_fader: RTL
==================

Name: rgb_pwm_fader

Overview:
Output-side counterpart to the debounced touch-pad input path. It accepts per-channel brightness targets over a valid/ready handshake and ramps each channel's duty toward its target. It generates glitch-free PWM bits for the red, green and blue inputs of the iCE40 SB_RGBA_DRV hard LED driver. It replaces static on/off enables so button logic can request colours and fades instead of raw LED levels.

Parameters:
TICK_DIV, 188, clk cycles per PWM phase step. At 48 MHz this gives about a 1 kHz PWM period. Minimum 1.
DUTY_W, 8, width of the duty and phase counters. The PWM period is 2^DUTY_W ticks.
FADE_PERIODS, 4, number of PWM periods per one-LSB ramp step. Minimum 1.

Ports:
clk  in  1  system clock (global-buffered 48 MHz)
rst  in  1  asynchronous, active-high reset
target_valid  in  1  a target write is offered
target_ready  out  1  staging register is empty and can accept a write
target_chan  in  2  0 = red, 1 = green, 2 = blue, 3 = all three
target_duty  in  DUTY_W  requested duty (0 = off, 2^DUTY_W-1 = max)
pwm_red  out  1  to the SB_RGBA_DRV red PWM input
pwm_green  out  1  to the SB_RGBA_DRV green PWM input
pwm_blue  out  1  to the SB_RGBA_DRV blue PWM input
busy  out  1  a write is staged, or any channel's current duty differs from its target

Behaviour:
- Reset (async assert, sync release):
  - prescaler, phase, fade counter, and all cur_duty and target values clear to 0.
  - stage_full = 0; all pwm_* = 0; busy = 0; target_ready = 0.
  - target_ready is registered and goes to 1 on the first clk edge after rst deasserts.
- Prescaler:
  - counts 0..TICK_DIV-1; tick = 1 on the cycle the count equals TICK_DIV-1, then the count wraps to 0.
  - TICK_DIV = 1 means tick on every cycle.
- Phase:
  - DUTY_W-bit counter that increments on tick and wraps from 2^DUTY_W-1 to 0.
  - period_start = tick while phase == 2^DUTY_W-1, i.e. the cycle the phase wraps.
- PWM output:
  - pwm_x is registered: pwm_x <= (phase < cur_duty_x).
  - Duty 0 means the output is never high; max duty gives (2^DUTY_W-1)/2^DUTY_W high time.
  - One-cycle latency from phase to pin.
- Handshake:
  - A transfer happens on a clk edge where target_valid && target_ready.
  - On transfer: latch chan/duty into the stage, stage_full <= 1, target_ready <= 0.
  - target_valid may stay high while ready is low; nothing is lost or duplicated.
  - Inputs need only be stable in the accepting cycle.
- Commit:
  - At period_start with stage_full = 1: target[chan] <= duty (all three when chan = 3); stage_full <= 0; target_ready <= 1 on the next edge.
  - A transfer and a commit cannot coincide, because ready is low while the stage is full.
- Fade (cur_duty changes only at period_start, so there are no mid-period glitches):
  - The fade counter increments at period_start; when it reaches FADE_PERIODS-1 it wraps to 0 and asserts step.
  - On step, each channel moves cur by ±1 toward its target; a channel with cur == target holds.
  - If commit and step share a period_start, step uses the pre-commit target; the new target affects the following step onward.
  - A new target mid-ramp reverses or redirects from the current cur value without jumping.
- busy: registered; = stage_full || any(cur != target).
- Reset mid-ramp or mid-handshake: everything returns to reset values immediately and the staged write is discarded.
- Width rule: all duty arithmetic is unsigned DUTY_W bits. Stepping never wraps, because cur stops when it equals target (0 and max are reached exactly).

Decomposition:
- Shared package:
  - channel encodings CH_RED = 0, CH_GREEN = 1, CH_BLUE = 2, CH_ALL = 3.
  - default DUTY_W.
  - a PWM-period constant computed from DUTY_W.
- Sub-module pwm_channel, instantiated three times. It holds target and cur, the step-toward logic and the registered comparator. Its inputs are phase, period_start, step, and a commit strobe with its duty value.
- The prescaler, phase counter, fade counter, staging register and handshake stay in the top module.

Test Plan (TICK_DIV = 2, FADE_PERIODS = 1, DUTY_W = 8; one period = 512 clk):
- Reset: hold rst for 5 cycles, then release.
  - While rst is high: all pwm_* = 0, target_ready = 0, busy = 0.
  - target_ready = 1 one cycle after release.
- Single write red = 4:
  - target_ready drops the next cycle and returns 1 cycle after the first period_start.
  - cur_red reaches 4 after 4 further periods; in that period pwm_red is high for exactly 8 clk (4 ticks × 2).
  - busy is 0 from then on.
- Backpressure: hold target_valid high with blue = 10, then green = 20, on consecutive requests.
  - The second write is accepted only after the first commits.
  - Both targets are applied; no write is dropped.
- CH_ALL = 255 from 0:
  - all three channels ramp together and reach 255 after 255 steps.
  - pwm_x is then low for exactly 2 clk per period.
  - Write 0 mid-ramp at cur = 100: cur reverses 99, 98, ... with no jump.
- Commit and step in the same cycle (FADE_PERIODS = 1, cur = target = 5, write 7):
  - at that period_start cur stays 5, then steps 6, 7 on the next two period_starts.
- Assert rst mid-ramp (cur = 50, stage full):
  - pwm_* drop to 0 asynchronously.
  - After release: target = 0, stage empty, ready = 1, no ramp resumes.

Source files
------------

// File: rtl/rgb_pwm_fader_pkg.sv
// Shared constants, channel encoding and helpers for the RGB PWM fader.
package rgb_pwm_fader_pkg;

   localparam int DUTY_W_DEF = 8;
   localparam int PWM_PERIOD = 1 << DUTY_W_DEF;

   typedef enum logic [1:0] {
      CH_RED   = 2'd0,
      CH_GREEN = 2'd1,
      CH_BLUE  = 2'd2,
      CH_ALL   = 2'd3
   } chan_e;

   function automatic logic chan_hit(input chan_e chan, input logic [1:0] idx);
      return (chan == CH_ALL) || (chan == chan_e'(idx));
   endfunction

endpackage

// File: rtl/rgb_pwm_fader_pwm_channel.sv
// One colour channel: target/current duty, one-LSB ramp and the
// registered phase comparator that drives the LED pin.
module rgb_pwm_fader_pwm_channel
   import rgb_pwm_fader_pkg::*;
#(
   parameter int DUTY_W = DUTY_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DUTY_W-1:0] phase,
   input  logic              period_start,
   input  logic              step,
   input  logic              commit,
   input  logic [DUTY_W-1:0] commit_duty,
   output logic              pwm,
   output logic              moving_d
);

   logic [DUTY_W-1:0] tgt_q, tgt_d;
   logic [DUTY_W-1:0] cur_q, cur_d;
   logic              pwm_q, pwm_d;

   // Step reads the pre-commit target, so a same-edge commit waits a step.
   always_comb begin
      tgt_d = tgt_q;
      cur_d = cur_q;
      pwm_d = (phase < cur_q);
      if (period_start && step) begin
         if (cur_q < tgt_q) begin
            cur_d = cur_q + 1'b1;
         end else if (cur_q > tgt_q) begin
            cur_d = cur_q - 1'b1;
         end
      end
      if (period_start && commit) begin
         tgt_d = commit_duty;
      end
      moving_d = (cur_d != tgt_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tgt_q <= '0;
         cur_q <= '0;
         pwm_q <= 1'b0;
      end else begin
         tgt_q <= tgt_d;
         cur_q <= cur_d;
         pwm_q <= pwm_d;
      end
   end

   assign pwm = pwm_q;

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB PWM fader: staged target writes, shared phase/fade timing and
// three ramping PWM channels for the SB_RGBA_DRV inputs.
module rgb_pwm_fader
   import rgb_pwm_fader_pkg::*;
#(
   parameter int TICK_DIV     = 188,
   parameter int DUTY_W       = DUTY_W_DEF,
   parameter int FADE_PERIODS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              target_valid,
   output logic              target_ready,
   input  logic [1:0]        target_chan,
   input  logic [DUTY_W-1:0] target_duty,
   output logic              pwm_red,
   output logic              pwm_green,
   output logic              pwm_blue,
   output logic              busy
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int FW = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [FW-1:0] FADE_LAST  = FW'(FADE_PERIODS - 1);

   logic [PW-1:0]     presc_q, presc_d;
   logic [DUTY_W-1:0] phase_q, phase_d;
   logic [FW-1:0]     fade_q, fade_d;
   logic              full_q, full_d;
   chan_e             chan_q, chan_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;

   logic              tick;
   logic              period_start;
   logic              step;
   logic              accept;
   logic              commit;
   logic [2:0]        pwm_vec;
   logic [2:0]        moving_vec;

   always_comb begin
      tick         = (presc_q == PRESC_LAST);
      presc_d      = tick ? '0 : presc_q + 1'b1;
      phase_d      = tick ? phase_q + 1'b1 : phase_q;
      period_start = tick && (phase_q == '1);
      step         = period_start && (fade_q == FADE_LAST);
      fade_d       = fade_q;
      if (period_start) begin
         fade_d = (fade_q == FADE_LAST) ? '0 : fade_q + 1'b1;
      end
   end

   // Ready is low whenever the stage is full, so accept and commit never overlap.
   always_comb begin
      accept = target_valid && ready_q;
      commit = period_start && full_q;
      full_d = full_q;
      chan_d = chan_q;
      duty_d = duty_q;
      if (commit) begin
         full_d = 1'b0;
      end else if (accept) begin
         full_d = 1'b1;
         chan_d = chan_e'(target_chan);
         duty_d = target_duty;
      end
      ready_d = !full_d;
      busy_d  = full_d || (|moving_vec);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         phase_q <= '0;
         fade_q  <= '0;
         full_q  <= 1'b0;
         chan_q  <= CH_RED;
         duty_q  <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         phase_q <= phase_d;
         fade_q  <= fade_d;
         full_q  <= full_d;
         chan_q  <= chan_d;
         duty_q  <= duty_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   for (genvar i = 0; i < 3; i++) begin : g_ch
      rgb_pwm_fader_pwm_channel #(
         .DUTY_W(DUTY_W)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .phase       (phase_q),
         .period_start(period_start),
         .step        (step),
         .commit      (commit && chan_hit(chan_q, 2'(i))),
         .commit_duty (duty_q),
         .pwm         (pwm_vec[i]),
         .moving_d    (moving_vec[i])
      );
   end

   assign target_ready = ready_q;
   assign busy         = busy_q;
   assign pwm_red      = pwm_vec[0];
   assign pwm_green    = pwm_vec[1];
   assign pwm_blue     = pwm_vec[2];

endmodule
